// File: rtl/dmem_responder.sv
// Wait-stated single-port data memory responder: one load/store in flight,
// valid/ready on both sides. Optional `DMEM_MISALIGN_CHECK_EN rejects addr[1:0]!=0.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
`ifdef DMEM_MISALIGN_CHECK_EN
  localparam bit MISALIGN_EN = 1'b1;
`else
  localparam bit MISALIGN_EN = 1'b0;
`endif

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic        lat_write;
  logic [31:0] lat_addr, lat_wdata;
  logic [31:0] mem [DEPTH_WORDS];

  logic          accept, commit, acc_write, acc_err;
  logic [31:0]   acc_addr, acc_wdata;
  logic [AW-1:0] acc_idx;

  assign req_ready  = (state == S_IDLE);
  assign resp_valid = (state == S_RESP);
  assign busy       = (state != S_IDLE);
  assign accept     = req_valid && req_ready;

  // Zero-wait builds commit straight from the request bus on the accept edge;
  // otherwise the access is committed from the latched copy at the end of WAIT.
  always_comb begin
    acc_write = lat_write;
    acc_addr  = lat_addr;
    acc_wdata = lat_wdata;
    if (state == S_IDLE) begin
      acc_write = req_write;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
    end
    commit  = (state == S_IDLE && accept && WAIT_CYCLES == 0) ||
              (state == S_WAIT && cnt == 4'd1);
    acc_err = (acc_addr[31:2] >= 30'(DEPTH_WORDS)) ||
              (MISALIGN_EN && (acc_addr[1:0] != 2'b00));
    acc_idx = acc_addr[AW+1:2];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= 4'd0;
      lat_write  <= 1'b0;
      lat_addr   <= 32'd0;
      lat_wdata  <= 32'd0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            lat_write <= req_write;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            cnt       <= 4'(WAIT_CYCLES);
            state     <= (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= S_RESP;
        end
        S_RESP: begin
          if (resp_ready) begin
            state      <= S_IDLE;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
      if (commit) begin
        resp_err   <= acc_err;
        resp_rdata <= (acc_write || acc_err) ? 32'd0 : mem[acc_idx];
      end
    end
  end

  // Storage is deliberately outside the reset domain; rst_n only blocks a write.
  always_ff @(posedge clk) begin
    if (rst_n && commit && acc_write && !acc_err) mem[acc_idx] <= acc_wdata;
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: vector table, backpressure/reset/zero-wait sequences,
// and randomized traffic against a word-array reference model.
module tb_dmem_responder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req_valid, req_ready, req_write, resp_valid, resp_ready, resp_err, busy;
  logic [31:0] req_addr, req_wdata, resp_rdata;
  logic        z_req_valid, z_req_ready, z_req_write, z_resp_valid, z_resp_ready, z_resp_err, z_busy;
  logic [31:0] z_req_addr, z_req_wdata, z_resp_rdata;

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .busy(busy));

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut_z (
    .clk(clk), .rst_n(rst_n), .req_valid(z_req_valid), .req_ready(z_req_ready),
    .req_write(z_req_write), .req_addr(z_req_addr), .req_wdata(z_req_wdata),
    .resp_valid(z_resp_valid), .resp_ready(z_resp_ready), .resp_rdata(z_resp_rdata),
    .resp_err(z_resp_err), .busy(z_busy));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: 256 words, with a flag for words whose content is known.
  logic [31:0] m [256];
  bit          known [256];

  function automatic void ref_acc(input logic w, input logic [31:0] a, input logic [31:0] d,
                                  output logic [31:0] rd, output logic er, output bit rd_known);
    int unsigned wi;
    wi = a / 4;
    er = (wi >= 256);
`ifdef DMEM_MISALIGN_CHECK_EN
    if (a % 4 != 0) er = 1'b1;
`endif
    rd = 32'd0;
    rd_known = 1'b1;
    if (!er) begin
      if (w) begin
        m[wi] = d;
        known[wi] = 1'b1;
      end else begin
        rd = m[wi];
        rd_known = known[wi];
      end
    end
  endfunction

  // One full transaction; lat counts cycles from the accept edge to resp_valid.
  task automatic access(input bit z, input logic w, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic er, output int lat);
    @(negedge clk);
    if (z) begin
      z_req_valid = 1'b1; z_req_write = w; z_req_addr = a; z_req_wdata = d;
    end else begin
      req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    end
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      req_valid = 1'b0;
      z_req_valid = 1'b0;
      lat++;
    end while (!(z ? z_resp_valid : resp_valid) && lat < 40);
    rd = z ? z_resp_rdata : resp_rdata;
    er = z ? z_resp_err : resp_err;
    if (z) z_resp_ready = 1'b1; else resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    z_resp_ready = 1'b0;
  endtask

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t        tv [11];
  logic [31:0] rd, mrd;
  logic        er, mer;
  bit          mk;
  int          lat;

  initial begin
    rst_n = 1'b0;
    req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; resp_ready = 0;
    z_req_valid = 0; z_req_write = 0; z_req_addr = 0; z_req_wdata = 0; z_resp_ready = 0;
    for (int i = 0; i < 256; i++) begin m[i] = 32'd0; known[i] = 1'b0; end

    tv[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 1'b0};
    tv[1]  = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
    tv[2]  = '{1'b1, 32'h0000_0000, 32'h1111_1111, 32'h0, 1'b0};
    tv[3]  = '{1'b1, 32'h0000_0020, 32'h0102_0304, 32'h0, 1'b0};
    tv[4]  = '{1'b1, 32'h0000_0400, 32'h1234_5678, 32'h0, 1'b1};
    tv[5]  = '{1'b0, 32'h0000_0400, 32'h0,         32'h0, 1'b1};
    tv[6]  = '{1'b0, 32'h0000_0000, 32'h0,         32'h1111_1111, 1'b0};
`ifdef DMEM_MISALIGN_CHECK_EN
    tv[7]  = '{1'b0, 32'h0000_0013, 32'h0,         32'h0, 1'b1};
`else
    tv[7]  = '{1'b0, 32'h0000_0013, 32'h0,         32'hDEAD_BEEF, 1'b0};
`endif
    tv[8]  = '{1'b1, 32'h0000_03FC, 32'hCAFE_F00D, 32'h0, 1'b0};
    tv[9]  = '{1'b0, 32'h0000_03FC, 32'h0,         32'hCAFE_F00D, 1'b0};
    tv[10] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         32'h0, 1'b1};

    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_z_req_ready", 32'(z_req_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      ref_acc(tv[i].w, tv[i].a, tv[i].d, mrd, mer, mk);
      access(1'b0, tv[i].w, tv[i].a, tv[i].d, rd, er, lat);
      chk($sformatf("vec%0d_rdata", i), rd, tv[i].exp_rd);
      chk($sformatf("vec%0d_err", i), 32'(er), 32'(tv[i].exp_err));
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd3);
    end

    // Backpressure: load 0x10 held in RESP while a store request waits.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10;
    @(posedge clk);
    @(negedge clk);
    req_write = 1'b1; req_addr = 32'h0; req_wdata = 32'h0BAD_0BAD;
    for (int i = 0; i < 40 && !resp_valid; i++) @(negedge clk);
    chk("bp_resp_valid", 32'(resp_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_valid", 32'(resp_valid), 32'd1);
      chk("bp_hold_rdata", resp_rdata, 32'hDEAD_BEEF);
      chk("bp_hold_req_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    @(negedge clk);
    chk("bp_not_early_ready", 32'(req_ready), 32'd1);
    chk("bp_not_early_busy", 32'(busy), 32'd0);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("bp_accept_busy", 32'(busy), 32'd1);
    ref_acc(1'b1, 32'h0, 32'h0BAD_0BAD, mrd, mer, mk);
    for (int i = 0; i < 40 && !resp_valid; i++) @(negedge clk);
    chk("bp_store_err", 32'(resp_err), 32'd0);
    chk("bp_store_rdata", resp_rdata, 32'd0);
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    access(1'b0, 1'b0, 32'h0, 32'h0, rd, er, lat);
    chk("bp_store_landed", rd, 32'h0BAD_0BAD);

    // Reset one cycle after accepting a store: the store must be dropped.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'hA5A5_A5A5;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("rw_busy_before", 32'(busy), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rw_busy", 32'(busy), 32'd0);
    chk("rw_req_ready", 32'(req_ready), 32'd1);
    chk("rw_resp_valid", 32'(resp_valid), 32'd0);
    chk("rw_resp_err", 32'(resp_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    access(1'b0, 1'b0, 32'h20, 32'h0, rd, er, lat);
    chk("rw_prior_value", rd, 32'h0102_0304);
    chk("rw_prior_err", 32'(er), 32'd0);

    // Zero-wait instance.
    access(1'b1, 1'b1, 32'h0, 32'h7777_0001, rd, er, lat);
    chk("z_store_latency", 32'(lat), 32'd1);
    chk("z_store_err", 32'(er), 32'd0);
    access(1'b1, 1'b0, 32'h0, 32'h0, rd, er, lat);
    chk("z_load_latency", 32'(lat), 32'd1);
    chk("z_load_rdata", rd, 32'h7777_0001);

    // Randomized traffic, including out-of-range and misaligned addresses.
    for (int i = 0; i < 80; i++) begin
      logic        w;
      logic [31:0] a, d;
      w = 1'($urandom_range(0, 1));
      a = 32'($urandom_range(0, 263)) << 2;
      if ($urandom_range(0, 3) == 0) a = a | 32'($urandom_range(1, 3));
      d = $urandom;
      ref_acc(w, a, d, mrd, mer, mk);
      access(1'b0, w, a, d, rd, er, lat);
      chk($sformatf("rnd%0d_err a=%h", i, a), 32'(er), 32'(mer));
      chk($sformatf("rnd%0d_latency", i), 32'(lat), 32'd3);
      if (mk) chk($sformatf("rnd%0d_rdata a=%h", i, a), rd, mrd);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 256; number of 32-bit storage words.
REQ-002 The block SHALL have parameter WAIT_CYCLES, default 2; wait-state count per access, legal range 0..15.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-low, ports: clk  input  1  rising-edge clock; rst_n  input  1  async active-low reset.
REQ-004 The block SHALL have port req_valid  input  1  CPU load/store request present.
REQ-005 The block SHALL have port req_ready  output  1  responder can accept a request.
REQ-006 The block SHALL have port req_write  input  1  1 = store, 0 = load.
REQ-007 The block SHALL have port req_addr  input  32  byte address.
REQ-008 The block SHALL have port req_wdata  input  32  store data.
REQ-009 The block SHALL have port resp_valid  output  1  response present.
REQ-010 The block SHALL have port resp_ready  input  1  CPU accepts response.
REQ-011 The block SHALL have port resp_rdata  output  32  load data; 0 for stores and errors.
REQ-012 The block SHALL have port resp_err  output  1  access rejected.
REQ-013 The block SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-014 The block SHALL implement FSM states IDLE, WAIT, RESP.
REQ-015 req_ready SHALL be 1 only in IDLE; a request is accepted on a rising edge with req_valid=1 and req_ready=1.
REQ-016 On accept, the block SHALL latch write, address and wdata, and load a wait counter with WAIT_CYCLES.
REQ-017 Transitions: IDLE->WAIT on accept when WAIT_CYCLES>0; IDLE->RESP on accept when WAIT_CYCLES=0; WAIT decrements each cycle and goes to RESP on the edge where the counter is 1.
REQ-018 The memory access SHALL be committed on the edge entering RESP: stores write mem[addr[31:2]], and loads capture mem[addr[31:2]] into resp_rdata.
REQ-019 resp_valid SHALL be 1 from the first cycle after the edge that enters RESP, so latency is WAIT_CYCLES+1 cycles from the accept edge.
REQ-020 RESP SHALL hold resp_valid, resp_rdata and resp_err stable until a rising edge with resp_ready=1, then go to IDLE; back-to-back requests therefore need at least one IDLE cycle.
REQ-021 A word index addr[31:2] >= DEPTH_WORDS SHALL give resp_err=1, perform no write, and return resp_rdata=0.
REQ-022 A load following a store to the same word SHALL return the stored data, with no forwarding hazards because accesses are serialized.
REQ-023 Inputs other than req_valid are don't-care outside the accept edge; req_valid held high in RESP SHALL NOT be accepted early.

Reset
REQ-024 While rst_n=0 the block SHALL hold state=IDLE, counter=0, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, busy=0.
REQ-025 Reset assertion in WAIT SHALL abort the access, leaving a pending store unwritten.
REQ-026 Reset assertion in RESP SHALL drop the response.
REQ-027 Memory contents SHALL NOT be cleared by reset.

Configuration
REQ-028 With macro DMEM_MISALIGN_CHECK_EN defined, a request with addr[1:0]!=0 SHALL complete with normal latency and resp_err=1, with no write and resp_rdata=0.
REQ-029 Without DMEM_MISALIGN_CHECK_EN, addr[1:0] SHALL be ignored.

Verification
REQ-030 Bench SHALL cover this scenario with WAIT_CYCLES=2: store 0xDEADBEEF to 0x10, then load 0x10 -> each resp_valid arrives 3 cycles after accept, and the load returns 0xDEADBEEF with resp_err=0.
REQ-031 Bench SHALL cover response backpressure: hold resp_ready=0 for 5 cycles in RESP -> resp_valid and resp_rdata stay stable, req_ready=0, and a new req_valid is not accepted until 1 cycle after the resp_ready handshake.
REQ-032 Bench SHALL cover an out-of-range access with DEPTH_WORDS=256: store 0x12345678 to 0x400, then load 0x400 -> resp_err=1 on both, with rdata=0 and no memory word changed.
REQ-033 Bench SHALL cover reset during WAIT: assert rst_n=0 one cycle after accepting a store of 0xA5A5A5A5 to 0x20 -> outputs go to reset values asynchronously, and a later load of 0x20 returns the prior value.
REQ-034 Bench SHALL cover a misaligned access: load 0x13 -> with DMEM_MISALIGN_CHECK_EN defined, resp_err=1 and rdata=0; without it, rdata=mem[4] and resp_err=0.
REQ-035 Bench SHALL cover the zero-wait build with WAIT_CYCLES=0: load 0x0 -> resp_valid 1 cycle after the accept edge.
